// File: rtl/modulo_varredura_matriz_pkg.sv
// ---------------------------------------------------------------------------
// pkg_matriz
// Shared definitions for the 5x7 LED matrix column-scan driver.
// Contents:
//   N_COL, N_LIN, PIX_W, COL_W : matrix geometry and column-index width
//   estado_t                   : scan FSM state encoding (IDLE, BLANK, SHOW)
//   PIX_APAGADO, LIN_APAGADA   : all-off image / all-off row drive (active-low)
//   fatia_coluna()             : extracts the 7 row bits of one column
// ---------------------------------------------------------------------------
package pkg_matriz;

    localparam int N_COL = 5;
    localparam int N_LIN = 7;
    localparam int PIX_W = N_COL * N_LIN;
    localparam int COL_W = $clog2(N_COL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } estado_t;

    localparam logic [PIX_W-1:0] PIX_APAGADO = '1;
    localparam logic [N_LIN-1:0] LIN_APAGADA = '1;

    // Column c occupies img[PIX_W-1-N_LIN*c -: N_LIN]; shifting it up to the
    // top of the word avoids a variable-base part-select.
    function automatic logic [N_LIN-1:0] fatia_coluna(
        input logic [PIX_W-1:0] img,
        input logic [COL_W-1:0] col
    );
        logic [PIX_W-1:0] w_desl;
        w_desl = img << (N_LIN * int'(col));
        return w_desl[PIX_W-1 -: N_LIN];
    endfunction

endpackage

// File: rtl/modulo_varredura_matriz_if.sv
// ---------------------------------------------------------------------------
// modulo_varredura_matriz_if
// Bus between the pixel-register side / LED pins and the scan driver.
//   en          : scan enable (0 = display dark)
//   m_in        : 35-bit pixel image, 1 = LED off
//   col_sel     : one-hot column drive, active-high
//   linhas      : row drive for the active column, active-low
//   frame_done  : 1-cycle pulse at each frame start
// Modports: master drives en/m_in and observes the outputs; slave is the
// scan driver.
// ---------------------------------------------------------------------------
interface modulo_varredura_matriz_if;
    import pkg_matriz::*;

    logic             en;
    logic [PIX_W-1:0] m_in;
    logic [N_COL-1:0] col_sel;
    logic [N_LIN-1:0] linhas;
    logic             frame_done;

    modport master (
        output en, m_in,
        input  col_sel, linhas, frame_done
    );

    modport slave (
        input  en, m_in,
        output col_sel, linhas, frame_done
    );

endinterface

// File: rtl/modulo_varredura_matriz_contador_fase.sv
// ---------------------------------------------------------------------------
// modulo_contador_fase
// Loadable down-counter timing one scan phase (BLANK or SHOW).
// Loaded with T-1 on phase entry, counts down to 0 and holds there; the
// terminal-count flag is high while the count is 0, so a phase lasts
// exactly T cycles.
// Ports:
//   clk      : system clock, rising edge
//   clr      : asynchronous active-high reset
//   i_load   : load i_val on the next edge (has priority over counting)
//   i_val    : reload value (T-1)
//   o_tc     : terminal count, count == 0
// ---------------------------------------------------------------------------
module modulo_contador_fase #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          i_load,
    input  logic [CW-1:0] i_val,
    output logic          o_tc
);

    logic [CW-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/modulo_varredura_matriz.sv
// ---------------------------------------------------------------------------
// modulo_varredura_matriz
// Column-scan driver for the 5x7 LED dot matrix. Snapshots the pixel image
// at each frame start, then drives one column at a time with optional blank
// time before each column, and pulses frame_done on the first cycle of
// every frame.
// Parameters:
//   T_SHOW  : cycles a column is driven (>= 1)
//   T_BLANK : cycles all columns are off before each column (0 = none)
// Ports:
//   clk  : system clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : slave side of modulo_varredura_matriz_if
//          (en, m_in in; col_sel, linhas, frame_done out)
// ---------------------------------------------------------------------------
module modulo_varredura_matriz
    import pkg_matriz::*;
#(
    parameter int T_SHOW  = 50000,
    parameter int T_BLANK = 500
) (
    input  logic                         clk,
    input  logic                         clr,
    modulo_varredura_matriz_if.slave     bus
);

    localparam int T_MAX = (T_SHOW > T_BLANK) ? T_SHOW : T_BLANK;
    localparam int CW    = $clog2(T_MAX + 1);

    localparam logic [CW-1:0]    LD_SHOW  = CW'(T_SHOW - 1);
    localparam logic [CW-1:0]    LD_BLANK = CW'((T_BLANK > 0) ? T_BLANK - 1 : 0);
    localparam logic [COL_W-1:0] ULTIMA   = COL_W'(N_COL - 1);
    localparam logic [N_COL-1:0] COL_UM   = N_COL'(1);

    // Every column starts in BLANK, except when there is no blank phase.
    localparam estado_t ST_ENTRADA = (T_BLANK > 0) ? BLANK : SHOW;

    estado_t          r_estado;
    logic [COL_W-1:0] r_col_idx;
    logic [PIX_W-1:0] r_snapshot;
    logic             r_frame_done;

    estado_t          w_estado_prox;
    logic [COL_W-1:0] w_col_prox;
    logic             w_carrega;
    logic             w_inicio_quadro;
    logic [CW-1:0]    w_val_carga;
    logic             w_tc;

    modulo_contador_fase #(
        .CW (CW)
    ) u_contador_fase (
        .clk    (clk),
        .clr    (clr),
        .i_load (w_carrega),
        .i_val  (w_val_carga),
        .o_tc   (w_tc)
    );

    // The phase being entered decides the reload value.
    assign w_val_carga = (w_estado_prox == SHOW) ? LD_SHOW : LD_BLANK;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_estado_prox   = r_estado;
        w_col_prox      = r_col_idx;
        w_carrega       = 1'b0;
        w_inicio_quadro = 1'b0;

        if (!bus.en) begin
            // Dropping enable abandons the partial frame from any state.
            w_estado_prox = IDLE;
            w_col_prox    = '0;
        end else begin
            unique case (r_estado)
                IDLE: begin
                    w_estado_prox   = ST_ENTRADA;
                    w_col_prox      = '0;
                    w_carrega       = 1'b1;
                    w_inicio_quadro = 1'b1;
                end
                BLANK: begin
                    if (w_tc) begin
                        w_estado_prox = SHOW;
                        w_carrega     = 1'b1;
                    end
                end
                SHOW: begin
                    if (w_tc) begin
                        w_estado_prox = ST_ENTRADA;
                        w_carrega     = 1'b1;
                        if (r_col_idx == ULTIMA) begin
                            // Wrap to column 0 is a back-to-back frame start.
                            w_col_prox      = '0;
                            w_inicio_quadro = 1'b1;
                        end else begin
                            w_col_prox = r_col_idx + COL_W'(1);
                        end
                    end
                end
                default: begin
                    w_estado_prox = IDLE;
                    w_col_prox    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_estado     <= IDLE;
            r_col_idx    <= '0;
            r_snapshot   <= PIX_APAGADO;
            r_frame_done <= 1'b0;
        end else begin
            r_estado     <= w_estado_prox;
            r_col_idx    <= w_col_prox;
            r_frame_done <= w_inicio_quadro;
            // Image only changes at frame boundaries, so a frame never tears.
            if (w_inicio_quadro) begin
                r_snapshot <= bus.m_in;
            end
        end
    end

    // Outputs decode registered state only; reset darkens them immediately.
    assign bus.col_sel    = (r_estado == SHOW) ? (COL_UM << r_col_idx) : '0;
    assign bus.linhas     = (r_estado == SHOW) ? fatia_coluna(r_snapshot, r_col_idx)
                                               : LIN_APAGADA;
    assign bus.frame_done = r_frame_done;

endmodule
